// File: rtl/bidirectional_shift_serializer.sv
// Parallel-in, serial-out shifter with a valid/ready load handshake.
// Emits one bit per enabled cycle, MSB-first (dir=0) or LSB-first (dir=1).
module bidirectional_shift_serializer #(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [MSB-1:0] din,
  input  logic           dir,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic           en,
  output logic           q,
  output logic           q_valid,
  output logic           last,
  output logic           busy
);

  localparam int            CW       = (MSB > 1) ? $clog2(MSB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MSB - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]     state;
  logic [MSB-1:0] shreg;
  logic           dir_l;
  logic [CW-1:0]  cnt;

  logic shifting;
  logic at_last;
  logic accept;

  assign shifting = (state == SHIFT);
  assign at_last  = (cnt == CNT_LAST);

  // A new word may only replace the current one on its final enabled bit,
  // which gives back-to-back words with no idle cycle between them.
  assign load_ready = !shifting || (en && at_last);
  assign accept     = load_valid && load_ready;

  assign q       = shifting && (dir_l ? shreg[0] : shreg[MSB-1]);
  assign q_valid = shifting;
  assign last    = shifting && at_last;
  assign busy    = shifting;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      shreg <= '0;
      dir_l <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= din;
      dir_l <= dir;
      cnt   <= '0;
    end else if (shifting && en) begin
      if (at_last) begin
        state <= IDLE;
        shreg <= '0;
        cnt   <= '0;
      end else begin
        if (dir_l) shreg <= {1'b0, shreg[MSB-1:1]};
        else       shreg <= {shreg[MSB-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bidirectional_shift_serializer.sv
// Randomized and directed bench for bidirectional_shift_serializer, checked
// against a word/index reference model and a behavioural receiver.
module tb_bidirectional_shift_serializer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] din = '0;
  logic       dir = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       en = 1'b0;
  logic       q, q_valid, last, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the word in flight, its bit order and which bit is on q.
  logic       m_busy;
  logic [7:0] m_word;
  logic       m_dir;
  int         m_idx;

  // Behavioural receiver fed from the observed q stream.
  logic [7:0] rx_acc;
  logic [7:0] rx_word;
  logic [7:0] rx_ref;
  logic       rx_done;

  bidirectional_shift_serializer #(.MSB(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din        (din),
    .dir        (dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .en         (en),
    .q          (q),
    .q_valid    (q_valid),
    .last       (last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_word  = '0;
    m_dir   = 1'b0;
    m_idx   = 0;
    rx_acc  = '0;
    rx_done = 1'b0;
  endfunction

  // Expected {q, q_valid, last, busy, load_ready} for the current cycle.
  function automatic logic [4:0] exp_out(input logic e);
    logic eq;
    logic eready;
    eready = !m_busy || (e && m_idx == 7);
    if (!m_busy) return {4'b0000, eready};
    eq = m_dir ? m_word[m_idx] : m_word[7 - m_idx];
    return {eq, 1'b1, (m_idx == 7), 1'b1, eready};
  endfunction

  // Drive one cycle starting from a falling edge; report observed and
  // expected outputs, then advance the model across the rising edge.
  task automatic cyc(input logic vld, input logic [7:0] d, input logic dr,
                     input logic e, output logic [4:0] obs, output logic [4:0] expv);
    load_valid = vld;
    din        = d;
    dir        = dr;
    en         = e;
    #1;
    obs  = {q, q_valid, last, busy, load_ready};
    expv = exp_out(e);
    @(posedge clk);
    if (obs[3] && e) begin
      rx_acc = m_dir ? {obs[4], rx_acc[7:1]} : {rx_acc[6:0], obs[4]};
      if (obs[2]) begin
        rx_word = rx_acc;
        rx_ref  = m_word;
        rx_done = 1'b1;
      end
    end
    if (vld && expv[0]) begin
      m_busy = 1'b1;
      m_word = d;
      m_dir  = dr;
      m_idx  = 0;
    end else if (m_busy && e) begin
      if (m_idx == 7) m_busy = 1'b0;
      else            m_idx++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] obs, expv;
    #1;
    vectors++;
    if ({q, q_valid, last, busy, load_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_initial: got %b want 00001", {q, q_valid, last, busy, load_ready});
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, obs, expv);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, obs, expv);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_preword bit%0d: got %b want %b", i, obs, expv);
      end
    end
    // Assert reset mid-word between clock edges.
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({q, q_valid, last, busy, load_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_async: got %b want 00001", {q, q_valid, last, busy, load_ready});
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, obs, expv);
    vectors++;
    if (obs !== 5'b00001 || obs !== expv) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 00001", obs);
    end
  endtask

  // Load a word with en held high and collect q in emission order.
  task automatic send_word(input logic [7:0] w, input logic dr, input string name,
                           input logic [7:0] want_seq);
    logic [4:0] obs, expv;
    logic [7:0] seq;
    seq = '0;
    cyc(1'b1, w, dr, 1'b1, obs, expv);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, obs, expv);
      seq = {seq[6:0], obs[4]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL %s bit%0d: got %b want %b", name, i, obs, expv);
      end
    end
    vectors++;
    if (seq !== want_seq) begin
      miscompares++;
      $display("FAIL %s sequence: got %b want %b", name, seq, want_seq);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, obs, expv);
    vectors++;
    if (obs !== 5'b00001) begin
      miscompares++;
      $display("FAIL %s idle_after: got %b want 00001", name, obs);
    end
  endtask

  task automatic test_msb_first();
    send_word(8'hA5, 1'b0, "msb_first_a5", 8'b1010_0101);
  endtask

  task automatic test_lsb_first();
    send_word(8'hA5, 1'b1, "lsb_first_a5", 8'b1010_0101);
    send_word(8'h01, 1'b1, "lsb_first_01", 8'b1000_0000);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  obs, expv;
    logic [15:0] seq;
    int          valid_cnt;
    seq = '0;
    valid_cnt = 0;
    cyc(1'b1, 8'hF0, 1'b0, 1'b1, obs, expv);
    for (int i = 0; i < 16; i++) begin
      cyc((i < 8), 8'h0F, 1'b1, 1'b1, obs, expv);
      seq = {seq[14:0], obs[4]};
      if (obs[3]) valid_cnt++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL back_to_back cycle%0d: got %b want %b", i, obs, expv);
      end
    end
    vectors++;
    if (seq !== 16'b1111_0000_1111_0000 || valid_cnt != 16) begin
      miscompares++;
      $display("FAIL back_to_back stream: got %b (%0d valid) want 1111000011110000 (16 valid)",
               seq, valid_cnt);
    end
  endtask

  task automatic test_stall();
    logic [4:0] obs, expv;
    logic [7:0] seq;
    logic [10:0] en_pat;
    int          cycles;
    seq    = '0;
    cycles = 0;
    en_pat = 11'b1_0001_1111_11;  // en per cycle, leftmost first: 1,0,0,0,1,...
    cyc(1'b1, 8'hC3, 1'b0, 1'b1, obs, expv);
    for (int i = 0; i < 11; i++) begin
      logic e;
      e = en_pat[10 - i];
      cyc(!e, 8'h55, 1'b1, e, obs, expv);
      if (obs[3]) cycles++;
      if (e) seq = {seq[6:0], obs[4]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL stall cycle%0d: got %b want %b", i, obs, expv);
      end
      if (!e) begin
        vectors++;
        if (obs[4] !== 1'b1 || obs[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL stall hold%0d: got q=%b ready=%b want q=1 ready=0", i, obs[4], obs[0]);
        end
      end
    end
    vectors++;
    if (seq !== 8'b1100_0011 || cycles != 11) begin
      miscompares++;
      $display("FAIL stall stream: got %b in %0d cycles want 11000011 in 11", seq, cycles);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, obs, expv);
    vectors++;
    if (obs !== 5'b00001) begin
      miscompares++;
      $display("FAIL stall idle_after: got %b want 00001", obs);
    end
  endtask

  task automatic test_loopback();
    logic [4:0] obs, expv;
    int         words;
    words = 0;
    rx_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic       v, dr, e;
      logic [7:0] d;
      v  = ($urandom_range(3) != 0);
      dr = $urandom_range(1);
      e  = ($urandom_range(3) != 0);
      d  = 8'($urandom);
      cyc(v, d, dr, e, obs, expv);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL loopback cycle%0d: got %b want %b", i, obs, expv);
      end
      if (rx_done) begin
        rx_done = 1'b0;
        words++;
        vectors++;
        if (rx_word !== rx_ref) begin
          miscompares++;
          $display("FAIL loopback word%0d: received %h want %h", words, rx_word, rx_ref);
        end
      end
    end
    vectors++;
    if (words < 20) begin
      miscompares++;
      $display("FAIL loopback word_count: got %0d want at least 20", words);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bidirectional_shift_serializer.md
# bidirectional_shift_serializer

Parallel-in, serial-out companion to the team's bidirectional serial-in shift register: it accepts an MSB-bit word through a valid/ready load handshake and emits it one bit per enabled cycle, MSB-first or LSB-first. Direction is captured per word. Bit order is defined so that feeding `q` into the receiver's `d` reconstructs the word: drive receiver `dir` equal to the `dir` latched here, and pulse receiver `en` on each cycle where `q_valid && en`. It sits on the transmit side of serial links and test loopbacks.

## Interface
- `MSB`, 8, word width in bits; legal range ≥ 2
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  asynchronous active-low reset
- `din`  in  MSB  parallel word to transmit
- `dir`  in  1  bit order for the word being loaded: 0 = MSB-first, 1 = LSB-first
- `load_valid`  in  1  `din`/`dir` are valid
- `load_ready`  out  1  block can accept a word this cycle (combinational)
- `en`  in  1  shift enable; 0 stalls the serializer, holding all state
- `q`  out  1  serial data bit (combinational from registered state)
- `q_valid`  out  1  `q` carries a word bit
- `last`  out  1  `q` is the final bit of the current word
- `busy`  out  1  a word is in flight (equal to `q_valid`)

## Operation
- States: IDLE, SHIFT. Internal registers: `shreg[MSB-1:0]`, `dir_l`, `cnt` (width `$clog2(MSB)`).
- Load accept: `load_valid && load_ready` at a rising edge. On accept, `shreg <= din`, `dir_l <= dir`, `cnt <= 0`, and `state <= SHIFT`.
- `load_ready = (state==IDLE) || (state==SHIFT && en && cnt==MSB-1)`. This gives zero-bubble back-to-back words.
- In SHIFT:
  - `q = dir_l ? shreg[0] : shreg[MSB-1]`.
  - `q_valid = 1`.
  - `last = (cnt==MSB-1)`.
- Shift step, on a SHIFT edge with `en=1` and `cnt<MSB-1`:
  - `dir_l=0`: `shreg <= {shreg[MSB-2:0],1'b0}`.
  - `dir_l=1`: `shreg <= {1'b0,shreg[MSB-1:1]}`.
  - `cnt <= cnt+1`.
- Final bit, on a SHIFT edge with `en=1` and `cnt==MSB-1`:
  - If a load is accepted on the same edge, the new word is loaded and the state stays SHIFT.
  - Otherwise `state <= IDLE` and `shreg <= 0`.
- `en=0` in SHIFT: all registers hold and `q`/`q_valid`/`last` stay stable. `load_ready` is 0 in this case, even on the last bit.
- In IDLE, `en` is ignored: `q=0`, `q_valid=0`, `last=0`.
- `load_valid` while in SHIFT and not on the final enabled bit: not accepted. `load_ready=0`; the source must hold the request.
- `dir` and `din` are sampled only on accept. Changes mid-word have no effect.

## Timing
- Reset, asynchronous while `rstn=0`:
  - state IDLE, `shreg=0`, `cnt=0`, `dir_l=0`.
  - Outputs: `q=0`, `q_valid=0`, `last=0`, `busy=0`, `load_ready=1`.
- Reset deasserting mid-word aborts the word. No partial bits resume.
- Latency: the first bit appears on `q` in the cycle after the accept edge.
- A word occupies exactly MSB enabled cycles. With `en` held high, word k+1's first bit directly follows word k's `last` cycle.
- Stalls extend the word by the number of `en=0` cycles. The bit order is unchanged.
- `last` is high for exactly one enabled cycle per word, plus any stalled cycles while on the final bit.

## Test plan
- Reset: assert `rstn=0` mid-word (after 3 bits of 8'hA5) → all outputs at reset values immediately, with no clock edge required; after release, `load_ready=1` and `q_valid=0`.
- MSB-first: load 8'hA5 with `dir=0`, `en=1` → `q` = 1,0,1,0,0,1,0,1 over 8 cycles; `last` only on the 8th; then IDLE with `q_valid=0`.
- LSB-first: load 8'hA5 with `dir=1` → `q` = 1,0,1,0,0,1,0,1 (LSB first). Load 8'h01 with `dir=1` → `q` = 1 then seven 0s.
- Back-to-back: load 8'hF0 (`dir=0`), then hold `load_valid` with 8'h0F (`dir=1`) → accepted on the last-bit edge; 16 contiguous `q_valid` cycles = 1111_0000 followed by 1,1,1,1,0,0,0,0.
- Stall: during 8'hC3 `dir=0`, drop `en` for 3 cycles after bit 2 → `q` holds bit 2 and `load_ready` stays 0; the sequence 1,1,0,0,0,0,1,1 completes in 11 cycles.
- Loopback: connect to the receiver (MSB=8, same `dir`, receiver `en = q_valid&&en`), send random words in both directions → the receiver `out` equals `din` after each `last` cycle.
